// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared 16-bit bus: one-hot registered grant, bounded hold
// with lock override, and a fixed idle turnaround between owners.
module bus_arbiter #(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned MAX_HOLD    = 8,
   parameter int unsigned TURN_CYCLES = 1,
   localparam int unsigned IDXW       = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             r,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] lock,
   output logic [N_REQ-1:0] gnt,
   output logic [IDXW-1:0]  owner,
   output logic             busy,
   output logic             preempt
);

   localparam int unsigned HOLDW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
   localparam int unsigned TURNW = 3;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

   state_t           state, state_d;
   logic [IDXW-1:0]  last, last_d, owner_d, pick;
   logic [HOLDW-1:0] hold_cnt, hold_d;
   logic [TURNW-1:0] turn_cnt, turn_d;
   logic [N_REQ-1:0] gnt_d, owner_mask;
   logic             preempt_d;
   logic             any_req, owner_req, others_wait, hold_full, turn_done, evict;

   assign any_req     = |req;
   assign owner_mask  = N_REQ'(1) << owner;
   assign owner_req   = |(req & owner_mask);
   assign others_wait = |(req & ~owner_mask);
   assign hold_full   = (MAX_HOLD != 0) && (hold_cnt == HOLDW'(MAX_HOLD));
   assign turn_done   = (turn_cnt == TURNW'(TURN_CYCLES));
   assign evict       = hold_full && !(|(lock & owner_mask)) && others_wait;

   // Round-robin pick: first requester after the last owner, wrapping
   always_comb begin
      int unsigned idx;
      logic        found;
      idx   = 0;
      found = 1'b0;
      pick  = last;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         idx = (32'(last) + k) % N_REQ;
         if (!found && req[idx[IDXW-1:0]]) begin
            found = 1'b1;
            pick  = idx[IDXW-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge r) begin
      if (r) begin
         state    <= S_IDLE;
         gnt      <= '0;
         owner    <= '0;
         busy     <= 1'b0;
         preempt  <= 1'b0;
         last     <= IDXW'(N_REQ - 1);
         hold_cnt <= '0;
         turn_cnt <= '0;
      end else begin
         state    <= state_d;
         gnt      <= gnt_d;
         owner    <= owner_d;
         busy     <= |gnt_d;
         preempt  <= preempt_d;
         last     <= last_d;
         hold_cnt <= hold_d;
         turn_cnt <= turn_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  if (any_req) state_d = S_GRANT;
         S_GRANT: if (!owner_req || evict) state_d = S_TURN;
         S_TURN:  if (turn_done) state_d = any_req ? S_GRANT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and counters; release beats preemption
   always_comb begin
      gnt_d     = gnt;
      owner_d   = owner;
      preempt_d = 1'b0;
      last_d    = last;
      hold_d    = hold_cnt;
      turn_d    = turn_cnt;
      case (state)
         S_IDLE: begin
            if (any_req) begin
               gnt_d   = N_REQ'(1) << pick;
               owner_d = pick;
               hold_d  = HOLDW'(1);
            end
         end
         S_GRANT: begin
            if (!owner_req || evict) begin
               gnt_d     = '0;
               last_d    = owner;
               turn_d    = TURNW'(1);
               preempt_d = owner_req;
            end else if (MAX_HOLD != 0 && !hold_full) begin
               hold_d = hold_cnt + HOLDW'(1);
            end
         end
         S_TURN: begin
            if (!turn_done) begin
               turn_d = turn_cnt + TURNW'(1);
            end else if (any_req) begin
               gnt_d   = N_REQ'(1) << pick;
               owner_d = pick;
               hold_d  = HOLDW'(1);
            end
         end
         default: begin
            gnt_d = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, directed corner sequences and
// randomized traffic against a cycle-level model of the arbitration rules.
module tb_bus_arbiter;

   localparam int N  = 4;
   localparam int MH = 8;
   localparam int TC = 1;

   logic       clk = 1'b0;
   logic       r;
   logic [3:0] req, lock, gnt;
   logic [1:0] owner;
   logic       busy, preempt;
   logic [3:0] req_b, lock_b, gnt_b;
   logic [1:0] owner_b;
   logic       busy_b, preempt_b;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.N_REQ(4), .MAX_HOLD(8), .TURN_CYCLES(1)) dut_a (
      .clk(clk), .r(r), .req(req), .lock(lock),
      .gnt(gnt), .owner(owner), .busy(busy), .preempt(preempt));

   bus_arbiter #(.N_REQ(4), .MAX_HOLD(0), .TURN_CYCLES(3)) dut_b (
      .clk(clk), .r(r), .req(req_b), .lock(lock_b),
      .gnt(gnt_b), .owner(owner_b), .busy(busy_b), .preempt(preempt_b));

   // Reference: who holds the bus, for how long, and how many idle cycles remain
   int m_cur, m_gap, m_held, m_last, m_owner;
   bit m_pre;

   function automatic void model_reset();
      m_cur = -1; m_gap = 0; m_held = 0; m_last = N - 1; m_owner = 0; m_pre = 1'b0;
   endfunction

   function automatic void model_step(logic [3:0] rq, logic [3:0] lk);
      logic [3:0] others;
      m_pre = 1'b0;
      if (m_cur >= 0) begin
         others = rq & ~(4'b0001 << m_cur);
         if (!rq[2'(m_cur)]) begin
            m_last = m_cur; m_cur = -1; m_gap = TC;
         end else if (MH != 0 && m_held >= MH && !lk[2'(m_cur)] && others != 0) begin
            m_last = m_cur; m_cur = -1; m_gap = TC; m_pre = 1'b1;
         end else begin
            m_held++;
         end
      end else begin
         if (m_gap > 0) m_gap--;
         if (m_gap == 0 && rq != 0) begin
            for (int k = 1; k <= N; k++) begin
               if (m_cur < 0 && rq[2'((m_last + k) % N)]) m_cur = (m_last + k) % N;
            end
            m_owner = m_cur;
            m_held  = 1;
         end
      end
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (r) model_reset();
      else model_step(req, lock);
      #1;
      chk("onehot_a", int'($onehot0(gnt)), 1);
      chk("busy_a", int'(busy), int'(|gnt));
      chk("onehot_b", int'($onehot0(gnt_b)), 1);
      chk("busy_b", int'(busy_b), int'(|gnt_b));
   endtask

   task automatic do_reset();
      r = 1'b1; req = '0; lock = '0; req_b = '0; lock_b = '0;
      tick();
      tick();
      r = 1'b0;
   endtask

   typedef struct {
      logic [3:0] req;
      logic [3:0] lock;
      logic [3:0] gnt;
      logic [1:0] owner;
      logic       busy;
      logic       pre;
   } vec_t;

   vec_t tbl[16];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Basic grant/release, then owner 2 releasing exactly at the hold limit
      tbl[0] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
      for (int i = 1; i <= 3; i++) tbl[i] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
      tbl[4] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
      for (int i = 5; i <= 11; i++) tbl[i] = '{4'b1100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
      tbl[12] = '{4'b1000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
      tbl[13] = '{4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
      tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};
      tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};

      r = 1'b1; req = '0; lock = '0; req_b = '0; lock_b = '0;
      model_reset();
      tick();
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_preempt", int'(preempt), 0);
      chk("rst_owner", int'(owner), 0);
      chk("rst_gnt_b", int'(gnt_b), 0);
      tick();
      r = 1'b0;

      foreach (tbl[i]) begin
         req = tbl[i].req; lock = tbl[i].lock;
         tick();
         chk($sformatf("tbl%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
         chk($sformatf("tbl%0d_owner", i), int'(owner), int'(tbl[i].owner));
         chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
         chk($sformatf("tbl%0d_pre", i), int'(preempt), int'(tbl[i].pre));
      end

      // All four requesting: hold limit rotates 0,1,2,3,0 with a preempt gap each time
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < MH; c++) begin
            tick();
            chk($sformatf("rot%0d_gnt", g), int'(gnt), int'(4'b0001 << (g % 4)));
            chk($sformatf("rot%0d_pre", g), int'(preempt), 0);
         end
         tick();
         chk($sformatf("rot%0d_gap", g), int'(gnt), 0);
         chk($sformatf("rot%0d_pulse", g), int'(preempt), 1);
      end
      req = '0;
      tick();

      // Lock holds owner 0 past the limit; dropping it preempts on the next edge
      do_reset();
      req = 4'b0011; lock = 4'b0001;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk("lock_gnt", int'(gnt), 1);
         chk("lock_pre", int'(preempt), 0);
      end
      lock = '0;
      tick();
      chk("unlock_gnt", int'(gnt), 0);
      chk("unlock_pre", int'(preempt), 1);
      tick();
      chk("unlock_next", int'(gnt), 2);
      chk("unlock_owner", int'(owner), 1);
      req = '0;
      tick();
      tick();

      // Asynchronous reset in the middle of a grant
      req = 4'b0100;
      tick();
      chk("pre_rst_gnt", int'(gnt), 4);
      #3 r = 1'b1;
      #1;
      chk("async_gnt", int'(gnt), 0);
      chk("async_busy", int'(busy), 0);
      chk("async_owner", int'(owner), 0);
      req = '0;
      tick();
      r = 1'b0;
      req = 4'b0110;
      tick();
      chk("ptr_reset_gnt", int'(gnt), 2);
      chk("ptr_reset_owner", int'(owner), 1);
      req = '0;
      tick();
      tick();

      // No hold limit and a three-cycle turnaround
      req_b = 4'b0101;
      for (int c = 0; c < 30; c++) begin
         tick();
         chk("nolimit_gnt", int'(gnt_b), 1);
         chk("nolimit_pre", int'(preempt_b), 0);
      end
      req_b = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("turn3_gap%0d", c), int'(gnt_b), 0);
      end
      tick();
      chk("turn3_gnt", int'(gnt_b), 4);
      chk("turn3_owner", int'(owner_b), 2);
      req_b = '0;
      tick();

      // Randomized traffic with sticky requests and locks against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(7) == 0) req[i] = ~req[i];
            if ($urandom_range(11) == 0) lock[i] = ~lock[i];
         end
         tick();
         chk("rnd_gnt", int'(gnt), (m_cur >= 0) ? (1 << m_cur) : 0);
         chk("rnd_owner", int'(owner), m_owner);
         chk("rnd_busy", int'(busy), (m_cur >= 0) ? 1 : 0);
         chk("rnd_pre", int'(preempt), int'(m_pre));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
